// File: rtl/jam_cost_table.sv
// 8x8 worker/job cost matrix for the JAM solver: streamed in row-major, then read combinationally.
// Optional JAM_COST_CHECKSUM_EN adds a registered running sum of accepted load beats.
module jam_cost_table #(
    parameter int COST_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    input  logic              LOAD_VALID,
    input  logic [COST_W-1:0] LOAD_DATA,
    output logic              LOAD_READY,
    output logic              TABLE_READY,
    output logic              OVERFLOW,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost
`ifdef JAM_COST_CHECKSUM_EN
    ,
    output logic [12:0]       CHECKSUM
`endif
);

    localparam int ADDR_W = 2 * IDX_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_count;
    logic [COST_W-1:0]   r_table [DEPTH];
    logic                r_table_ready;
    logic                r_overflow;
    logic                w_accept;
    logic                w_last;
    logic [ADDR_W-1:0]   w_idx;

    assign LOAD_READY = ~CLEAR & (r_state != S_DONE);
    assign w_accept   = LOAD_VALID & LOAD_READY;
    assign w_last     = (r_count == ADDR_W'(DEPTH - 1));
    assign w_idx      = {W, J};

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (CLEAR) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next_state = S_LOAD;
                S_LOAD:  if (w_accept && w_last) w_next_state = S_DONE;
                default: w_next_state = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_table_ready <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_table_ready <= (w_next_state == S_DONE);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (CLEAR) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_count <= r_count + ADDR_W'(1);
            // Beats arriving after the table is full are dropped but remembered.
            if ((r_state == S_DONE) && LOAD_VALID) r_overflow <= 1'b1;
        end
    end

    // NOTE: the table lives in flops, not RAM, because reset and CLEAR must zero all entries at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
        end else if (w_accept) begin
            r_table[r_count] <= LOAD_DATA;
        end
    end

`ifdef JAM_COST_CHECKSUM_EN
    logic [12:0] r_checksum;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_checksum <= '0;
        end else if (CLEAR) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + 13'(LOAD_DATA);
        end
    end

    assign CHECKSUM = r_checksum;
`endif

    assign TABLE_READY = r_table_ready;
    assign OVERFLOW    = r_overflow;
    assign Cost        = r_table_ready ? r_table[w_idx] : '0;

endmodule
